// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder.
// Holds the access-size encoding, the responder FSM states and the alignment check.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_SIZE_BYTE = 2'b00,
    MEM_ACCESS_SIZE_HALF = 2'b01,
    MEM_ACCESS_SIZE_WORD = 2'b10
  } mem_access_size_t;

  localparam logic [1:0] MEM_ACCESS_SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    MEM_RSP_IDLE = 2'b00,
    MEM_RSP_WAIT = 2'b01,
    MEM_RSP_RESP = 2'b10
  } mem_rsp_state_t;

  // Only the two low address bits matter for alignment.
  function automatic logic mem_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    return ((size == MEM_ACCESS_SIZE_HALF) && addr_lo[0]) ||
           ((size == MEM_ACCESS_SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering between right-justified core data and word-organised storage.
// Purely combinational: write enables/replicated data and extracted read data.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rword_i >> {offset_i, 3'b000};
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = '0;
    case (size_i)
      MEM_ACCESS_SIZE_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, shifted[7:0]};
      end
      MEM_ACCESS_SIZE_HALF: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, shifted[15:0]};
      end
      MEM_ACCESS_SIZE_WORD: begin
        be_o    = 4'b1111;
        rdata_o = shifted;
      end
      default: begin
        be_o    = 4'b0000;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder with programmable wait states, lane steering
// and error reporting in front of a word-organised storage array.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request transfers on a rising clk_i edge where req_valid_i && req_ready_o;
  // the response is a single-cycle rsp_valid_o strobe with no backpressure.

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);

  mem_rsp_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_error_q, rsp_error_d;

  logic [31:0] storage_q [DEPTH_WORDS];

  logic [31:0]      req_off;
  logic             req_err;
  logic             use_live, cur_we, cur_err, enter_resp, wr_en;
  logic [1:0]       cur_size, cur_lane;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      cur_wdata;
  logic [3:0]       be;
  logic [31:0]      wdata_lanes, rdata_lanes;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign req_off = req_addr_i - BASE_ADDR;
  assign req_err = mem_misaligned(req_addr_i[1:0], req_size_i) ||
                   (req_off >= SPAN_BYTES) ||
                   (req_size_i == MEM_ACCESS_SIZE_ILLEGAL);

  // With zero wait states the accept edge is also the commit edge, so use the live request.
  assign use_live  = (state_q == MEM_RSP_IDLE);
  assign cur_we    = use_live ? req_we_i        : we_q;
  assign cur_size  = use_live ? req_size_i      : size_q;
  assign cur_lane  = use_live ? req_addr_i[1:0] : lane_q;
  assign cur_idx   = use_live ? req_off[IDX_W+1:2] : idx_q;
  assign cur_wdata = use_live ? req_wdata_i     : wdata_q;
  assign cur_err   = use_live ? req_err         : err_q;

  mem_lane_align u_lane_align (
    .size_i   (cur_size),
    .offset_i (cur_lane),
    .wdata_i  (cur_wdata),
    .rword_i  (storage_q[cur_idx]),
    .be_o     (be),
    .wdata_o  (wdata_lanes),
    .rdata_o  (rdata_lanes)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    we_d       = we_q;
    size_d     = size_q;
    lane_d     = lane_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      MEM_RSP_IDLE: begin
        ready_d = 1'b1;
        if (req_valid_i && ready_q) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          lane_d  = req_addr_i[1:0];
          idx_d   = req_off[IDX_W+1:2];
          wdata_d = req_wdata_i;
          err_d   = req_err;
          cnt_d   = WAIT_INIT;
          ready_d = 1'b0;
          if (WAIT_INIT != 4'd0) begin
            state_d = MEM_RSP_WAIT;
          end else begin
            state_d    = MEM_RSP_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      MEM_RSP_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = MEM_RSP_RESP;
          enter_resp = 1'b1;
        end
      end
      MEM_RSP_RESP: begin
        state_d = MEM_RSP_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = MEM_RSP_IDLE;
        ready_d = 1'b0;
      end
    endcase
    rsp_valid_d = enter_resp;
    rsp_error_d = enter_resp && cur_err;
    rsp_rdata_d = (enter_resp && !cur_err && !cur_we) ? rdata_lanes : '0;
    wr_en       = enter_resp && cur_we && !cur_err;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= MEM_RSP_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Storage contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) storage_q[cur_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign dbg_state_o = state_q;

endmodule
